// File: rtl/nes_fbwr.sv
// Framebuffer writer: queues visible NES pixels in a FIFO and writes them as 32-bit words
// into one of two external framebuffers, flipping buffers at each frame end.
module nes_fbwr #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  outx,
  input  logic [8:0]  outy,
  input  logic        pxvalid,
  input  logic [23:0] pix,
  input  logic [31:0] base0,
  input  logic [31:0] base1,
  input  logic        swapen,
  input  logic        clrovf,
  output logic [31:0] memaddr,
  output logic [31:0] memwdata,
  output logic        memreq,
  input  logic        memack,
  output logic        stall,
  output logic        fbsel,
  output logic        framedone,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl  = (AW+1)'(DEPTH);
  localparam logic [AW:0] StallLvl = (AW+1)'(DEPTH - 4);

  logic [15:0] off_mem  [DEPTH];
  logic [23:0] pix_mem  [DEPTH];
  logic        last_mem [DEPTH];

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          stall_q, fbsel_q, framedone_q, overflow_q;

  logic        visible, last_in, push, pop, drop;
  logic [15:0] head_off;
  logic [23:0] head_pix;
  logic        head_last;

  assign visible   = pxvalid && (outx[8] == 1'b0) && (outy < 9'd240);
  assign last_in   = (outx == 9'd255) && (outy == 9'd239);
  assign memreq    = (count_q != '0);
  assign pop       = memreq && memack;
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign push      = visible && ((count_q < FullLvl) || pop);
  assign drop      = visible && !push;

  assign head_off  = off_mem[rptr_q];
  assign head_pix  = pix_mem[rptr_q];
  assign head_last = last_mem[rptr_q];

  // Base selected at pop time, so entries behind a frame's last pixel land in the new buffer.
  assign memaddr   = (fbsel_q ? base1 : base0) +
                     {14'b0, (memreq ? head_off : 16'h0000), 2'b00};
  assign memwdata  = memreq ? {8'h00, head_pix} : 32'h0000_0000;

  assign stall     = stall_q;
  assign fbsel     = fbsel_q;
  assign framedone = framedone_q;
  assign overflow  = overflow_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      off_mem[wptr_q]  <= {outy[7:0], outx[7:0]};
      pix_mem[wptr_q]  <= pix;
      last_mem[wptr_q] <= last_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      stall_q     <= 1'b0;
      fbsel_q     <= 1'b0;
      framedone_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q     <= count_d;
      stall_q     <= (count_d >= StallLvl);
      framedone_q <= pop && head_last;
      if (pop && head_last && swapen) fbsel_q <= ~fbsel_q;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clrovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule
